trdb_resync_handler: RTL and testbench
======================================

TRDB_RESYNC_HANDLER -- requirements
Module: trdb_resync_handler

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 16: cycles a resync may wait for a qualified instruction before late_o is set.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port trace_enabled_i  input  1  tracing active.
REQ-005 SHALL have port et_resync_max_i  input  1  resync counter equal to its max value.
REQ-006 SHALL have port gt_resync_max_i  input  1  resync counter beyond its max value (missed resync).
REQ-007 SHALL have port qualified_i  input  1  qualified retired instruction this cycle.
REQ-008 SHALL have port sync_ack_i  input  1  packet emitter accepts the sync request.
REQ-009 SHALL have port sync_emitted_i  input  1  sync packet emitted for another reason (trace start, exception).
REQ-010 SHALL have port sync_req_o  output  1  request to emit a format-3 sync packet.
REQ-011 SHALL have port resync_rst_o  output  1  one-cycle pulse clearing the resync counter.
REQ-012 SHALL have port resync_pending_o  output  1  high in PENDING or REQ.
REQ-013 SHALL have port late_o  output  1  sticky: a PENDING wait reached WAIT_MAX.
REQ-014 SHALL have port overflow_o  output  1  sticky: gt_resync_max_i seen while enabled.

Function
REQ-015 SHALL implement FSM states IDLE, PENDING, REQ, RST.
REQ-016 IDLE -> PENDING when trace_enabled_i & (et_resync_max_i | gt_resync_max_i).
REQ-017 PENDING -> REQ on the cycle after qualified_i=1.
REQ-018 REQ SHALL hold sync_req_o=1, a Moore output, until sync_ack_i=1 in the same cycle; handshake completes that cycle, then REQ -> RST.
REQ-019 RST SHALL drive resync_rst_o=1 for exactly one cycle, then go unconditionally to IDLE.
REQ-020 sync_emitted_i=1 in PENDING or REQ SHALL go to RST next cycle (pending resync satisfied).
REQ-021 sync_emitted_i=1 in IDLE with trace enabled SHALL go to RST (counter cleared), taking priority over et/gt.
REQ-022 sync_ack_i and sync_emitted_i together in REQ SHALL give a single RST pulse.
REQ-023 sync_ack_i outside REQ SHALL be ignored.
REQ-024 et/gt inputs in PENDING, REQ or RST SHALL not restart the wait or create a second request.
REQ-025 wait counter, width $clog2(WAIT_MAX+1):
  - cleared on entry to PENDING
  - increments each PENDING cycle with qualified_i=0
  - saturates at WAIT_MAX
  - late_o set when it equals WAIT_MAX
REQ-026 overflow_o SHALL set on any cycle with trace_enabled_i & gt_resync_max_i, in any state.
REQ-027 late_o and overflow_o SHALL clear only on reset.
REQ-028 trace_enabled_i=0 in any state SHALL force IDLE next cycle, clear the wait counter, and give no resync_rst_o pulse.
REQ-029 trace_enabled_i=0 SHALL take priority over all other transitions.
REQ-030 sync_req_o and resync_rst_o SHALL never be high in the same cycle.

Reset
REQ-031 Reset SHALL force state IDLE, wait counter 0, and every output to 0 immediately, independent of clk.
REQ-032 Reset asserted mid-request (REQ) SHALL drop sync_req_o at once and give no resync_rst_o pulse after release.
REQ-033 First transition SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-034 Bench SHALL run WAIT_MAX=4 with trace enabled and cover these scenarios:
  - Nominal: et=1 at cycle 0, qualified_i=1 at cycle 2, sync_ack_i=1 at cycle 4 -> sync_req_o high cycles 3-4, resync_rst_o high cycle 5 only, IDLE at cycle 6.
  - Timeout: et=1, qualified_i=0 for 6 cycles -> late_o=1 after 4th PENDING cycle and remains 1; resync_pending_o=1 throughout.
  - Other sync: PENDING then sync_emitted_i=1 -> no sync_req_o; one resync_rst_o pulse next cycle; IDLE.
  - Overflow plus simultaneous events: gt=1 in IDLE -> PENDING, overflow_o=1 sticky; in REQ, ack and sync_emitted same cycle -> exactly one resync_rst_o pulse.
  - Disable/reset: trace_enabled_i=0 during REQ -> sync_req_o=0 next cycle, no pulse; async reset mid-cycle -> all outputs 0 before next edge.

Source files
------------

// File: rtl/trdb_resync_handler.sv
// Trace resync handler: turns a resync-counter expiry into a format-3 sync request,
// waits for a qualified instruction, and pulses the counter clear once the sync is out.
module trdb_resync_handler #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic trace_enabled_i,
  input  logic et_resync_max_i,
  input  logic gt_resync_max_i,
  input  logic qualified_i,
  input  logic sync_ack_i,
  input  logic sync_emitted_i,
  output logic sync_req_o,
  output logic resync_rst_o,
  output logic resync_pending_o,
  output logic late_o,
  output logic overflow_o
);

  localparam int unsigned CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(WAIT_MAX);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] REQ     = 2'd2;
  localparam logic [1:0] RST     = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          late_q, late_d;
  logic          overflow_q, overflow_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;

    if (!trace_enabled_i) begin
      state_d    = IDLE;
      wait_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // An unrelated sync already re-anchors the trace, so it wins over a counter expiry.
          if (sync_emitted_i) begin
            state_d = RST;
          end else if (et_resync_max_i || gt_resync_max_i) begin
            state_d    = PENDING;
            wait_cnt_d = '0;
          end
        end
        PENDING: begin
          if (sync_emitted_i) begin
            state_d = RST;
          end else if (qualified_i) begin
            state_d = REQ;
          end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
          end
        end
        REQ: begin
          if (sync_ack_i || sync_emitted_i) begin
            state_d = RST;
          end
        end
        RST:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    late_d     = late_q | (wait_cnt_d == WAIT_LIMIT);
    overflow_d = overflow_q | (trace_enabled_i & gt_resync_max_i);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      late_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      late_q     <= late_d;
      overflow_q <= overflow_d;
    end
  end

  // Moore outputs decoded from the state register, so reset clears them without waiting for clk.
  assign sync_req_o       = (state_q == REQ);
  assign resync_rst_o     = (state_q == RST);
  assign resync_pending_o = (state_q == PENDING) || (state_q == REQ);
  assign late_o           = late_q;
  assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_trdb_resync_handler.sv
// Directed bench for trdb_resync_handler with WAIT_MAX=4; outputs are checked as a packed
// vector {sync_req, resync_rst, resync_pending, late, overflow}.
module tb_trdb_resync_handler;

  logic clk = 1'b0;
  logic reset;
  logic trace_enabled_i, et_resync_max_i, gt_resync_max_i;
  logic qualified_i, sync_ack_i, sync_emitted_i;
  logic sync_req_o, resync_rst_o, resync_pending_o, late_o, overflow_o;
  logic [4:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  trdb_resync_handler #(.WAIT_MAX(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .trace_enabled_i  (trace_enabled_i),
    .et_resync_max_i  (et_resync_max_i),
    .gt_resync_max_i  (gt_resync_max_i),
    .qualified_i      (qualified_i),
    .sync_ack_i       (sync_ack_i),
    .sync_emitted_i   (sync_emitted_i),
    .sync_req_o       (sync_req_o),
    .resync_rst_o     (resync_rst_o),
    .resync_pending_o (resync_pending_o),
    .late_o           (late_o),
    .overflow_o       (overflow_o)
  );

  assign outs = {sync_req_o, resync_rst_o, resync_pending_o, late_o, overflow_o};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got req/rst/pend/late/ovf=%b expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 ns after the edge, away from sampling.
  task automatic step();
    @(posedge clk);
    #1;
    check("excl", {4'b0, sync_req_o & resync_rst_o}, 5'b00000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    trace_enabled_i = 1'b1;
    et_resync_max_i = 1'b0;
    gt_resync_max_i = 1'b0;
    qualified_i     = 1'b0;
    sync_ack_i      = 1'b0;
    sync_emitted_i  = 1'b0;
    #2;
    check("reset", outs, 5'b00000);
    #10;
    reset = 1'b0;

    // Nominal: et at cycle 0, qualified at 2, ack at 4
    et_resync_max_i = 1'b1;
    step(); et_resync_max_i = 1'b0;
    check("nom_c1", outs, 5'b00100);
    step();
    check("nom_c2", outs, 5'b00100);
    qualified_i = 1'b1;
    step(); qualified_i = 1'b0;
    check("nom_c3", outs, 5'b10100);
    step();
    check("nom_c4", outs, 5'b10100);
    sync_ack_i = 1'b1;
    step(); sync_ack_i = 1'b0;
    check("nom_c5", outs, 5'b01000);
    step();
    check("nom_c6", outs, 5'b00000);

    // Ack while idle is ignored
    sync_ack_i = 1'b1;
    step(); sync_ack_i = 1'b0;
    check("ack_idle", outs, 5'b00000);

    // Timeout: four unqualified PENDING cycles set late; et mid-wait must not restart it
    et_resync_max_i = 1'b1;
    step(); et_resync_max_i = 1'b0;
    check("to_enter", outs, 5'b00100);
    step();
    step();
    check("to_w2", outs, 5'b00100);
    step();
    check("to_w3", outs, 5'b00100);
    et_resync_max_i = 1'b1;
    step(); et_resync_max_i = 1'b0;
    check("to_late", outs, 5'b00110);
    step();
    step();
    check("to_hold", outs, 5'b00110);
    qualified_i = 1'b1;
    step(); qualified_i = 1'b0;
    check("to_req", outs, 5'b10110);
    sync_ack_i = 1'b1;
    step(); sync_ack_i = 1'b0;
    check("to_rst", outs, 5'b01010);
    step();
    check("to_idle", outs, 5'b00010);

    // Other sync while PENDING satisfies the resync
    et_resync_max_i = 1'b1;
    step(); et_resync_max_i = 1'b0;
    check("os_pend", outs, 5'b00110);
    sync_emitted_i = 1'b1;
    step(); sync_emitted_i = 1'b0;
    check("os_rst", outs, 5'b01010);
    step();
    check("os_idle", outs, 5'b00010);

    // Other sync in IDLE clears the counter, even with et asserted
    sync_emitted_i  = 1'b1;
    et_resync_max_i = 1'b1;
    step(); sync_emitted_i = 1'b0; et_resync_max_i = 1'b0;
    check("idle_emit", outs, 5'b01010);
    step();
    check("idle_emit2", outs, 5'b00010);

    // Overflow, then ack and sync_emitted together in REQ
    gt_resync_max_i = 1'b1;
    step(); gt_resync_max_i = 1'b0;
    check("ovf_pend", outs, 5'b00111);
    qualified_i = 1'b1;
    step(); qualified_i = 1'b0;
    check("ovf_req", outs, 5'b10111);
    sync_ack_i = 1'b1; sync_emitted_i = 1'b1;
    step(); sync_ack_i = 1'b0; sync_emitted_i = 1'b0;
    check("both_rst", outs, 5'b01011);
    step();
    check("both_idle", outs, 5'b00011);
    step();
    check("both_once", outs, 5'b00011);

    // Disable during REQ: drop to IDLE, no clear pulse
    et_resync_max_i = 1'b1;
    step(); et_resync_max_i = 1'b0;
    qualified_i = 1'b1;
    step(); qualified_i = 1'b0;
    check("dis_req", outs, 5'b10111);
    trace_enabled_i = 1'b0;
    step();
    check("dis_off", outs, 5'b00011);
    trace_enabled_i = 1'b1;
    step();
    check("dis_nopulse", outs, 5'b00011);

    // Async reset in REQ, between clock edges
    et_resync_max_i = 1'b1;
    step(); et_resync_max_i = 1'b0;
    qualified_i = 1'b1;
    step(); qualified_i = 1'b0;
    check("ar_req", outs, 5'b10111);
    #2 reset = 1'b1;
    #1 check("ar_async", outs, 5'b00000);
    #1 reset = 1'b0;
    et_resync_max_i = 1'b1;
    step(); et_resync_max_i = 1'b0;
    check("ar_first_edge", outs, 5'b00100);
    step();
    check("ar_nopulse", outs, 5'b00100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
